// File: rtl/coalescing_store_buffer_if.sv
// Store, load-forward and memory-drain signals of the coalescing store buffer.
// The slave modport is the buffer; the master modport is its client.
interface coalescing_store_buffer_if #(
    parameter int DATA_BITS = 32,
    parameter int ADDR_BITS = 32,
    parameter int IDX_BITS  = 3
);
    logic                   flush;
    logic                   drain;
    logic                   wr_req;
    logic [ADDR_BITS-1:0]   wr_addr;
    logic [DATA_BITS-1:0]   wr_data;
    logic [DATA_BITS/8-1:0] wr_be;
    logic                   wr_ready;
    logic                   rd_req;
    logic [ADDR_BITS-1:0]   rd_addr;
    logic [DATA_BITS-1:0]   rd_data;
    logic [DATA_BITS/8-1:0] rd_be;
    logic                   rd_hit;
    logic                   rd_partial;
    logic                   mem_req;
    logic [ADDR_BITS-1:0]   mem_addr;
    logic [DATA_BITS-1:0]   mem_data;
    logic [DATA_BITS/8-1:0] mem_be;
    logic                   mem_ack;
    logic [IDX_BITS:0]      count;
    logic                   full;
    logic                   empty;

    modport slave (
        input  flush, drain, wr_req, wr_addr, wr_data, wr_be,
        input  rd_req, rd_addr, mem_ack,
        output wr_ready, rd_data, rd_be, rd_hit, rd_partial,
        output mem_req, mem_addr, mem_data, mem_be,
        output count, full, empty
    );

    modport master (
        output flush, drain, wr_req, wr_addr, wr_data, wr_be,
        output rd_req, rd_addr, mem_ack,
        input  wr_ready, rd_data, rd_be, rd_hit, rd_partial,
        input  mem_req, mem_addr, mem_data, mem_be,
        input  count, full, empty
    );
endinterface

// File: rtl/coalescing_store_buffer.sv
// Byte-masked circular store buffer: merges into the youngest entry,
// forwards bytes to loads, drains in order under a hold/issue policy.
module coalescing_store_buffer #(
    parameter int DATA_BITS    = 32,
    parameter int ADDR_BITS    = 32,
    parameter int SLOTS        = 8,
    parameter int IDX_BITS     = 3,
    parameter int COALESCE     = 1,
    parameter int DRAIN_THRESH = 4,
    parameter int MAX_AGE      = 15
) (
    input logic clk,
    input logic rst,
    coalescing_store_buffer_if.slave bus
);
    localparam int BE_BITS  = DATA_BITS / 8;
    localparam int LSB      = $clog2(BE_BITS);
    localparam int WA_BITS  = ADDR_BITS - LSB;
    localparam int AGE_BITS = $clog2(MAX_AGE + 2);
    localparam logic [IDX_BITS:0] CNT_FULL = (IDX_BITS + 1)'(SLOTS);
    localparam logic [IDX_BITS:0] CNT_THR  = (IDX_BITS + 1)'(DRAIN_THRESH);
    localparam logic [IDX_BITS:0] CNT_TWO  = (IDX_BITS + 1)'(2);
    localparam logic [AGE_BITS-1:0] AGE_LIM = AGE_BITS'(MAX_AGE);

    typedef enum logic {HOLD, ISSUE} state_t;

    logic [WA_BITS-1:0]   slotAddr [SLOTS];
    logic [DATA_BITS-1:0] slotData [SLOTS];
    logic [BE_BITS-1:0]   slotBe   [SLOTS];
    logic [SLOTS-1:0]     slotValid;

    logic [IDX_BITS-1:0] head;
    logic [IDX_BITS-1:0] tail;
    logic [IDX_BITS-1:0] youngest;
    logic [IDX_BITS-1:0] scan;
    logic [IDX_BITS:0]   count;
    logic [IDX_BITS:0]   nextCount;
    logic [AGE_BITS-1:0] age;
    state_t              state;
    logic                memReq;

    logic [WA_BITS-1:0]   wrWord;
    logic [WA_BITS-1:0]   rdWord;
    logic [DATA_BITS-1:0] fwdData;
    logic [BE_BITS-1:0]   fwdBe;
    logic coalesce;
    logic push;
    logic pop;
    logic ageHit;
    logic unusedLow;

    assign wrWord   = bus.wr_addr[ADDR_BITS-1:LSB];
    assign rdWord   = bus.rd_addr[ADDR_BITS-1:LSB];
    assign youngest = tail - IDX_BITS'(1);
    assign unusedLow = ^{bus.wr_addr[LSB-1:0], bus.rd_addr[LSB-1:0]};

    // count>=2 keeps the in-flight head out of reach of a merge
    assign coalesce = (COALESCE != 0) && bus.wr_req
                   && (count >= CNT_TWO)
                   && slotValid[youngest]
                   && (slotAddr[youngest] == wrWord);
    assign push = bus.wr_req && !coalesce
               && (count != CNT_FULL) && !bus.flush;
    assign pop  = memReq && bus.mem_ack && !bus.flush;
    assign nextCount = count + (IDX_BITS + 1)'(push)
                             - (IDX_BITS + 1)'(pop);
    assign ageHit = (MAX_AGE != 0) && (age == AGE_LIM);

    assign bus.wr_ready = coalesce || (count != CNT_FULL);
    assign bus.count    = count;
    assign bus.full     = (count == CNT_FULL);
    assign bus.empty    = (count == '0);
    assign bus.mem_req  = memReq;
    assign bus.mem_addr = {slotAddr[head], {LSB{1'b0}}};
    assign bus.mem_data = slotData[head];
    assign bus.mem_be   = slotBe[head];

    // Oldest to youngest scan; later matches overwrite, so youngest wins
    always_comb begin
        fwdData = '0;
        fwdBe   = '0;
        scan    = head;
        for (int i = 0; i < SLOTS; i++) begin
            scan = head + IDX_BITS'(i);
            if (bus.rd_req && slotValid[scan]
                && (slotAddr[scan] == rdWord)) begin
                for (int b = 0; b < BE_BITS; b++) begin
                    if (slotBe[scan][b]) begin
                        fwdData[b*8 +: 8] = slotData[scan][b*8 +: 8];
                        fwdBe[b] = 1'b1;
                    end
                end
            end
        end
    end

    assign bus.rd_data    = fwdData;
    assign bus.rd_be      = fwdBe;
    assign bus.rd_hit     = &fwdBe;
    assign bus.rd_partial = (|fwdBe) && !(&fwdBe);

    // Entry payload: merge into the youngest or write a fresh slot at tail
    always_ff @(posedge clk) begin
        for (int b = 0; b < BE_BITS; b++) begin
            if (coalesce && !bus.flush && bus.wr_be[b]) begin
                slotData[youngest][b*8 +: 8] <= bus.wr_data[b*8 +: 8];
                slotBe[youngest][b] <= 1'b1;
            end
            if (push) begin
                slotData[tail][b*8 +: 8] <=
                    bus.wr_be[b] ? bus.wr_data[b*8 +: 8] : 8'h00;
            end
        end
        if (push) begin
            slotAddr[tail] <= wrWord;
            slotBe[tail]   <= bus.wr_be;
        end
    end

    // Pointers, occupancy and the hold/issue drain FSM
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            slotValid <= '0;
            state     <= HOLD;
            memReq    <= 1'b0;
            age       <= '0;
        end else begin
            if (push) begin
                slotValid[tail] <= 1'b1;
                tail <= tail + IDX_BITS'(1);
            end
            if (pop) begin
                slotValid[head] <= 1'b0;
                head <= head + IDX_BITS'(1);
            end
            count <= nextCount;
            unique case (state)
                HOLD: begin
                    if (count == '0) begin
                        age <= '0;
                    end else if (count >= CNT_THR || bus.drain
                                 || ageHit) begin
                        state  <= ISSUE;
                        memReq <= 1'b1;
                    end else if (age != '1) begin
                        age <= age + AGE_BITS'(1);
                    end
                end
                ISSUE: begin
                    if (pop && (nextCount == '0
                        || (nextCount < CNT_THR && !bus.drain))) begin
                        state  <= HOLD;
                        memReq <= 1'b0;
                        age    <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_coalescing_store_buffer.sv
// Randomized and directed bench for the coalescing store buffer,
// checked against a queue-based reference model.
module tb_coalescing_store_buffer;
    localparam int DB = 32;
    localparam int AB = 32;
    localparam int SL = 8;
    localparam int IB = 3;
    localparam int TH = 4;
    localparam int MA = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    coalescing_store_buffer_if #(
        .DATA_BITS(DB), .ADDR_BITS(AB), .IDX_BITS(IB)
    ) bus ();
    coalescing_store_buffer_if #(
        .DATA_BITS(DB), .ADDR_BITS(AB), .IDX_BITS(IB)
    ) bus2 ();

    coalescing_store_buffer #(
        .DATA_BITS(DB), .ADDR_BITS(AB), .SLOTS(SL),
        .IDX_BITS(IB), .COALESCE(1), .DRAIN_THRESH(TH),
        .MAX_AGE(MA)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    coalescing_store_buffer #(
        .DATA_BITS(DB), .ADDR_BITS(AB), .SLOTS(SL),
        .IDX_BITS(IB), .COALESCE(0), .DRAIN_THRESH(TH),
        .MAX_AGE(MA)
    ) dutNc (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    typedef struct {
        logic [29:0] wa;
        logic [31:0] d;
        logic [3:0]  be;
    } ent_t;

    ent_t q[$];
    bit   mIssue;
    int   mAge;
    int   tests;
    int   fails;
    int   dutWrites;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bmask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++)
            if (be[b]) m[b*8 +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic bit canMerge();
        if (!bus.wr_req || q.size() < 2) return 1'b0;
        return q[q.size()-1].wa == bus.wr_addr[31:2];
    endfunction

    task automatic checkAll();
        logic [31:0] ed;
        logic [3:0]  eb;
        check("count", bus.count, q.size());
        check("full", bus.full, q.size() == SL);
        check("empty", bus.empty, q.size() == 0);
        check("wr_ready", bus.wr_ready, canMerge() || q.size() < SL);
        check("mem_req", bus.mem_req, mIssue);
        if (mIssue && q.size() > 0) begin
            check("mem_addr", bus.mem_addr, {q[0].wa, 2'b00});
            check("mem_be", bus.mem_be, q[0].be);
            check("mem_data", bus.mem_data & bmask(q[0].be), q[0].d);
        end
        ed = '0;
        eb = '0;
        if (bus.rd_req) begin
            foreach (q[i]) begin
                if (q[i].wa == bus.rd_addr[31:2]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (q[i].be[b]) begin
                            ed[b*8 +: 8] = q[i].d[b*8 +: 8];
                            eb[b] = 1'b1;
                        end
                    end
                end
            end
        end
        check("rd_data", bus.rd_data, ed);
        check("rd_be", bus.rd_be, eb);
        check("rd_hit", bus.rd_hit, eb == 4'hF);
        check("rd_partial", bus.rd_partial, eb != 4'h0 && eb != 4'hF);
    endtask

    task automatic modelStep();
        bit   coal;
        bit   push;
        bit   pop;
        int   n;
        ent_t e;
        if (rst || bus.flush) begin
            q.delete();
            mIssue = 1'b0;
            mAge = 0;
            return;
        end
        coal = canMerge();
        push = bus.wr_req && !coal && q.size() < SL;
        pop  = mIssue && bus.mem_ack;
        n = q.size() - int'(pop) + int'(push);
        if (!mIssue) begin
            if (q.size() == 0) mAge = 0;
            else if (q.size() >= TH || bus.drain || mAge == MA)
                mIssue = 1'b1;
            else mAge++;
        end else if (pop && (n == 0 || (n < TH && !bus.drain))) begin
            mIssue = 1'b0;
            mAge = 0;
        end
        if (coal) begin
            e = q[q.size()-1];
            for (int b = 0; b < 4; b++) begin
                if (bus.wr_be[b]) begin
                    e.d[b*8 +: 8] = bus.wr_data[b*8 +: 8];
                    e.be[b] = 1'b1;
                end
            end
            q[q.size()-1] = e;
        end
        if (pop) void'(q.pop_front());
        if (push) begin
            e.wa = bus.wr_addr[31:2];
            e.d  = bus.wr_data & bmask(bus.wr_be);
            e.be = bus.wr_be;
            q.push_back(e);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        checkAll();
        if (bus.mem_req && bus.mem_ack && !bus.flush && !rst)
            dutWrites++;
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic setIdle();
        bus.flush = 0; bus.drain = 0; bus.wr_req = 0;
        bus.wr_addr = '0; bus.wr_data = '0; bus.wr_be = '0;
        bus.rd_req = 0; bus.rd_addr = '0; bus.mem_ack = 0;
    endtask

    task automatic setIdle2();
        bus2.flush = 0; bus2.drain = 0; bus2.wr_req = 0;
        bus2.wr_addr = '0; bus2.wr_data = '0; bus2.wr_be = '0;
        bus2.rd_req = 0; bus2.rd_addr = '0; bus2.mem_ack = 0;
    endtask

    task automatic store(input logic [31:0] a,
                         input logic [31:0] d,
                         input logic [3:0] be,
                         input bit both);
        bus.wr_req = 1; bus.wr_addr = a;
        bus.wr_data = d; bus.wr_be = be;
        if (both) begin
            bus2.wr_req = 1; bus2.wr_addr = a;
            bus2.wr_data = d; bus2.wr_be = be;
        end
        cycle();
        bus.wr_req = 0;
        bus2.wr_req = 0;
    endtask

    task automatic drainAll();
        int n;
        n = 0;
        bus.drain = 1;
        bus.mem_ack = 1;
        while (!bus.empty && n < 200) begin
            cycle();
            n++;
        end
        check("drain_done", bus.empty, 1'b1);
        bus.drain = 0;
        bus.mem_ack = 0;
        cycle();
    endtask

    initial begin
        int w;
        int w0;
        tests = 0;
        fails = 0;
        dutWrites = 0;
        setIdle();
        setIdle2();
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        q.delete();
        mIssue = 0;
        mAge = 0;
        check("rst_count", bus.count, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_wr_ready", bus.wr_ready, 1);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_rd_be", bus.rd_be, 0);
        rst = 0;

        // age-triggered drain of three stores
        store(32'h100, 32'hAAAA0001, 4'hF, 0);
        store(32'h104, 32'hBBBB0002, 4'hF, 0);
        store(32'h108, 32'hCCCC0003, 4'hF, 0);
        check("t1_count", bus.count, 3);
        bus.mem_ack = 1;
        w = 0;
        while (!bus.mem_req && w < 100) begin
            cycle();
            w++;
        end
        check("t1_age_wait", w, 14);
        check("t1_first_addr", bus.mem_addr, 32'h100);
        check("t1_first_data", bus.mem_data, 32'hAAAA0001);
        w = 0;
        while (dutWrites < 3 && w < 100) begin
            cycle();
            w++;
        end
        check("t1_writes", dutWrites, 3);
        bus.mem_ack = 0;
        cycle();
        check("t1_empty", bus.empty, 1);

        // coalescing into the youngest entry
        store(32'h200, 32'h11223344, 4'hF, 1);
        store(32'h204, 32'h55667788, 4'hF, 1);
        store(32'h204, 32'h000000FF, 4'h1, 1);
        check("t2_count", bus.count, 2);
        check("t2_count_nc", bus2.count, 3);
        bus.rd_req = 1;
        bus.rd_addr = 32'h204;
        bus2.rd_req = 1;
        bus2.rd_addr = 32'h204;
        #1;
        check("t2_fwd", bus.rd_data, 32'h556677FF);
        check("t2_hit", bus.rd_hit, 1);
        check("t2_fwd_nc", bus2.rd_data, 32'h556677FF);
        cycle();
        bus.rd_req = 0;
        bus2.rd_req = 0;
        bus2.flush = 1;
        cycle();
        bus2.flush = 0;
        check("t2_nc_flushed", bus2.count, 0);
        drainAll();

        // partial forwarding, then forced drain of two entries
        store(32'h300, 32'h0000BEEF, 4'h3, 0);
        store(32'h300, 32'h0000CC00, 4'h2, 0);
        check("t3_count", bus.count, 2);
        bus.rd_req = 1;
        bus.rd_addr = 32'h300;
        #1;
        check("t3_data", bus.rd_data, 32'h0000CCEF);
        check("t3_be", bus.rd_be, 4'h3);
        check("t3_partial", bus.rd_partial, 1);
        check("t3_hit", bus.rd_hit, 0);
        bus.rd_req = 0;
        w0 = dutWrites;
        bus.drain = 1;
        bus.mem_ack = 1;
        cycle();
        check("t5_issue", bus.mem_req, 1);
        cycle();
        cycle();
        check("t5_mem_req", bus.mem_req, 0);
        check("t5_empty", bus.empty, 1);
        check("t5_writes", dutWrites - w0, 2);
        bus.drain = 0;
        bus.mem_ack = 0;
        cycle();

        // fill, refuse while full, then wrap the pointers
        for (int i = 0; i < 8; i++)
            store(32'h400 + 4 * i, $urandom, 4'hF, 0);
        check("t4_full", bus.full, 1);
        bus.wr_req = 1;
        bus.wr_addr = 32'h480;
        bus.wr_data = 32'hDEADBEEF;
        bus.wr_be = 4'hF;
        #1;
        check("t4_ready", bus.wr_ready, 0);
        bus.mem_ack = 1;
        cycle();
        bus.wr_req = 0;
        bus.mem_ack = 0;
        check("t4_refused", bus.count, 7);
        for (int i = 0; i < 12; i++) begin
            bus.mem_ack = $urandom_range(0, 1);
            store(32'h500 + 4 * i, $urandom, 4'(i + 1), 0);
        end
        bus.mem_ack = 0;
        drainAll();

        // flush in the middle of an issue
        for (int i = 0; i < 5; i++)
            store(32'h600 + 4 * i, $urandom, 4'hF, 0);
        cycle();
        check("t6_issue", bus.mem_req, 1);
        w0 = dutWrites;
        bus.flush = 1;
        bus.mem_ack = 1;
        bus.wr_req = 1;
        bus.wr_addr = 32'h700;
        bus.wr_be = 4'hF;
        cycle();
        bus.flush = 0;
        bus.wr_req = 0;
        check("t6_count", bus.count, 0);
        check("t6_mem_req", bus.mem_req, 0);
        repeat (5) cycle();
        check("t6_no_writes", dutWrites - w0, 0);
        bus.mem_ack = 0;
        bus.rd_req = 1;
        bus.rd_addr = 32'h604;
        #1;
        check("t6_rd_be", bus.rd_be, 0);
        bus.rd_req = 0;

        // randomized traffic over a small address window
        for (int i = 0; i < 3000; i++) begin
            bus.wr_req  = $urandom_range(0, 1);
            bus.wr_addr = 32'h800 + 4 * $urandom_range(0, 3)
                        + $urandom_range(0, 3);
            bus.wr_data = $urandom;
            bus.wr_be   = 4'($urandom_range(0, 15));
            bus.rd_req  = $urandom_range(0, 1);
            bus.rd_addr = 32'h800 + 4 * $urandom_range(0, 4)
                        + $urandom_range(0, 3);
            bus.mem_ack = $urandom_range(0, 1);
            bus.drain   = ($urandom_range(0, 7) == 0);
            bus.flush   = ($urandom_range(0, 99) == 0);
            rst         = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst = 0;
        setIdle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/coalescing_store_buffer.md
Name: coalescing_store_buffer

Overview:
- Parametrised, byte-masked store buffer between the data cache and memory.
- Accepts stores into a circular FIFO and merges same-word stores into the youngest entry.
- Forwards bytes to loads with youngest-wins byte merging and partial-hit reporting.
- Drains entries to memory in order under a threshold/age/forced-drain policy.

Parameters:
- DATA_BITS, 32, data word width; must be a multiple of 8.
- ADDR_BITS, 32, byte address width.
- SLOTS, 8, number of entries; power of two, ≥2.
- IDX_BITS, 3, log2(SLOTS).
- COALESCE, 1, 1 enables merging into the youngest entry.
- DRAIN_THRESH, 4, occupancy at which draining starts; 1..SLOTS.
- MAX_AGE, 15, HOLD cycles with count>0 before a forced drain; 0 disables the age trigger.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous discard of all entries.
- drain  in  1  level; forces issue until empty.
- wr_req  in  1  store request.
- wr_addr  in  ADDR_BITS  store byte address; word-aligned use of bits [ADDR_BITS-1:log2(DATA_BITS/8)].
- wr_data  in  DATA_BITS  store data.
- wr_be  in  DATA_BITS/8  byte enables.
- wr_ready  out  1  store accepted this cycle when wr_req && wr_ready.
- rd_req  in  1  load lookup.
- rd_addr  in  ADDR_BITS  load address.
- rd_data  out  DATA_BITS  forwarded bytes; bytes not covered are 0.
- rd_be  out  DATA_BITS/8  bytes supplied by the buffer.
- rd_hit  out  1  all bytes covered.
- rd_partial  out  1  some but not all bytes covered.
- mem_req  out  1  head entry presented to memory.
- mem_addr  out  ADDR_BITS  head word address; low byte bits are 0.
- mem_data  out  DATA_BITS  head data.
- mem_be  out  DATA_BITS/8  head byte enables.
- mem_ack  in  1  memory accepted the head entry.
- count  out  IDX_BITS+1  valid entries.
- full  out  1  count==SLOTS.
- empty  out  1  count==0.

Behaviour:
- Reset (rst=1 at posedge):
  - head=tail=0, count=0, all valid bits 0, FSM=HOLD, age=0.
  - Outputs: mem_req=0, wr_ready=1, rd_*=0, empty=1, full=0.
- Coalesce condition:
  - COALESCE=1 && wr_req && count≥2 && word address matches entry tail-1.
  - The head entry is never merged into, because it may be in flight.
  - On coalesce, for each set wr_be bit: data byte ← wr_data byte, be bit ← 1. count is unchanged.
- Push condition (no coalesce):
  - New entry at tail with wr_be, then tail←tail+1 mod SLOTS.
- wr_ready (combinational) = coalesce condition || count<SLOTS.
  - Push while full is refused even if mem_ack pops in the same cycle.
- Pop:
  - On mem_req && mem_ack: invalidate head, head←head+1 mod SLOTS.
  - Push and pop in the same cycle leave count unchanged.
- Forwarding (combinational, zero latency):
  - Gated by rd_req; all outputs are 0 when rd_req=0.
  - Scan valid entries from youngest (tail-1) to oldest. Each byte lane takes the youngest entry with a matching word address and that be bit set.
  - rd_hit = &rd_be; rd_partial = |rd_be && !rd_hit.
  - A store written in cycle N is visible to loads from cycle N+1.
  - The head stays forwardable until the posedge at which it is acked.
- FSM, HOLD → ISSUE when count>0 and any of:
  - count≥DRAIN_THRESH
  - drain=1
  - MAX_AGE≠0 && age==MAX_AGE
- In HOLD, age increments each cycle while count>0 (saturating) and clears when count==0.
- ISSUE:
  - mem_req=1; mem_addr/data/be are held stable from the head until mem_ack.
  - After an ack, go to HOLD (age←0) if the new count is 0, or if the new count<DRAIN_THRESH && drain=0. Otherwise stay in ISSUE.
  - mem_req drops in the cycle after the last ack.
- flush:
  - All valid bits cleared; head=tail=0, count=0, FSM=HOLD, age=0 at the next edge.
  - flush wins over a simultaneous wr_req and mem_ack; the store is dropped and wr_ready is ignored.
  - rst has priority over flush.
- Wrap-around: indices are mod SLOTS, and full/empty are derived from count, never from head==tail.
- No memory write is ever issued twice or out of order.

Test Plan:
- Reset, then push 3 stores (0x100/0xAAAA0001, 0x104, 0x108; be=0xF), DRAIN_THRESH=4, drain=0 → count=3, mem_req=0 until age reaches 15, then 3 in-order writes on mem_req/mem_ack.
- Push 0x200 be=0xF data 0x11223344, then 0x204, then 0x204 be=0x1 data 0xFF → count=2, and entry 0x204 holds byte0=0xFF with upper bytes merged; with COALESCE=0 → count=3.
- Stores 0x300 be=0x3 data 0x0000BEEF, then 0x300 be=0x2 data 0x0000CC00 (forced separate entries, head in flight); load 0x300 → rd_data=0x0000CCEF, rd_be=0x3, rd_partial=1, rd_hit=0.
- Fill 8 entries with mem_ack=0 → full=1, wr_ready=0. Push attempt plus mem_ack in the same cycle → push refused, count=7 next cycle. Continue pushing to exercise tail wrap → order preserved.
- drain=1 with count=2 → ISSUE immediately, 2 writes, mem_req=0 in the cycle after the second ack, empty=1.
- Assert flush mid-ISSUE with mem_ack=1 → count=0, mem_req=0 next cycle, no further writes, and a subsequent load to a flushed address → rd_be=0.
